// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//   Shared front end for the I2C controllers on one bus. The block
//   synchronises and glitch-filters the raw SCL/SDA pad samples. It then
//   produces edge pulses and START / repeated-START / STOP events, and tracks
//   bus ownership with a bus-free hold-off. A bit/byte framer delivers each
//   received byte and its ACK bit.
//
//   Optional feature macro: I2C_TIMEOUT_EN
//     When this macro is defined, the bus is forced back to IDLE if SCL is
//     held low in ACTIVE for TIMEOUT_CYCLES cycles. sclTimeout pulses once
//     when that happens. Without the macro, sclTimeout is tied to 0.
//
//   Ports
//     clk, rst_an            clock, asynchronous active-low reset
//     rawScl, rawSda         raw pad samples
//     scl, sda               filtered line values
//     sclRise/sclFall,
//     sdaRise/sdaFall        one-cycle filtered edge pulses
//     start, rstart, stop    bus condition pulses
//     busBusy                high in ACTIVE and FREE_WAIT
//     bitCnt                 bits received in the current frame (0..8)
//     byteValid, dataByte    byte strobe on the 8th SCL rise, last byte (MSB first)
//     ackValid, ackBit       ACK strobe on the 9th SCL rise, sampled SDA
//     sclTimeout             SCL-low timeout pulse
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_DEPTH     = 3,
  parameter int BUSFREE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       rawScl,
  input  logic       rawSda,
  output logic       scl,
  output logic       sda,
  output logic       sclRise,
  output logic       sclFall,
  output logic       sdaRise,
  output logic       sdaFall,
  output logic       start,
  output logic       rstart,
  output logic       stop,
  output logic       busBusy,
  output logic [3:0] bitCnt,
  output logic       byteValid,
  output logic [7:0] dataByte,
  output logic       ackValid,
  output logic       ackBit,
  output logic       sclTimeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FREE_WAIT = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [3:0] scl_fcnt, sda_fcnt;
  logic       scl_f, sda_f, scl_prev, sda_prev;
  logic       start_cond, stop_cond, in_active, to_hit;
  state_t     state_q, state_d;
  logic [7:0] bf_cnt_q, bf_cnt_d;
  logic [3:0] bit_cnt_q;
  logic [6:0] sr_q;
  logic [7:0] data_q;
  logic       ack_q;

  // Synchroniser and filter. The filter toggles on the FILT_DEPTH-th
  // consecutive cycle that the synchronised value disagrees with it.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_fcnt <= '0;
      sda_fcnt <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], rawScl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], rawSda};
      scl_prev <= scl_f;
      sda_prev <= sda_f;
      if (scl_sync[SYNC_STAGES-1] != scl_f) begin
        if (scl_fcnt == 4'(FILT_DEPTH - 1)) begin
          scl_f    <= ~scl_f;
          scl_fcnt <= '0;
        end else begin
          scl_fcnt <= scl_fcnt + 4'd1;
        end
      end else begin
        scl_fcnt <= '0;
      end
      if (sda_sync[SYNC_STAGES-1] != sda_f) begin
        if (sda_fcnt == 4'(FILT_DEPTH - 1)) begin
          sda_f    <= ~sda_f;
          sda_fcnt <= '0;
        end else begin
          sda_fcnt <= sda_fcnt + 4'd1;
        end
      end else begin
        sda_fcnt <= '0;
      end
    end
  end

  assign scl     = scl_f;
  assign sda     = sda_f;
  assign sclRise = scl_f & ~scl_prev;
  assign sclFall = ~scl_f & scl_prev;
  assign sdaRise = sda_f & ~sda_prev;
  assign sdaFall = ~sda_f & sda_prev;

  // SCL must be high in both cycles, so a condition can never sit on an SCL edge.
  assign start_cond = sdaFall & scl_f & scl_prev;
  assign stop_cond  = sdaRise & scl_f & scl_prev;
  assign in_active  = (state_q == ACTIVE);
  assign busBusy    = (state_q != IDLE);

`ifdef I2C_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  assign to_hit     = in_active && !scl_f && (to_cnt_q == 16'(TIMEOUT_CYCLES));
  assign sclTimeout = to_hit;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an)                           to_cnt_q <= '0;
    else if (in_active && !scl_f && !to_hit) to_cnt_q <= to_cnt_q + 16'd1;
    else                                   to_cnt_q <= '0;
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign to_hit             = 1'b0;
  assign sclTimeout         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q  <= IDLE;
      bf_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bf_cnt_q <= bf_cnt_d;
    end
  end

  // The STOP cycle already has both lines high. It therefore counts as the
  // first bus-free cycle.
  always_comb begin
    state_d  = state_q;
    bf_cnt_d = '0;
    start    = 1'b0;
    rstart   = 1'b0;
    stop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_cond) begin
          start   = 1'b1;
          state_d = ACTIVE;
        end else if (stop_cond) begin
          stop = 1'b1;
        end
      end
      ACTIVE: begin
        if (start_cond) begin
          rstart = 1'b1;
        end else if (stop_cond) begin
          stop     = 1'b1;
          state_d  = FREE_WAIT;
          bf_cnt_d = 8'd1;
        end else if (to_hit) begin
          state_d = IDLE;
        end
      end
      FREE_WAIT: begin
        if (start_cond) begin
          start   = 1'b1;
          state_d = ACTIVE;
        end else begin
          stop = stop_cond;
          if (scl_f && sda_f) begin
            if (({1'b0, bf_cnt_q} + 9'd1) >= 9'(BUSFREE_CYCLES)) state_d = IDLE;
            else bf_cnt_d = bf_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Framer: bits 1..8 shift in on SCL rises, and the 9th rise is the ACK slot.
  // The byte and ACK outputs bypass their holding registers in the strobe
  // cycle.
  assign byteValid = in_active && sclRise && (bit_cnt_q == 4'd7);
  assign ackValid  = in_active && sclRise && (bit_cnt_q == 4'd8);
  assign dataByte  = byteValid ? {sr_q, sda_f} : data_q;
  assign ackBit    = ackValid ? sda_f : ack_q;
  assign bitCnt    = bit_cnt_q;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      bit_cnt_q <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      ack_q     <= 1'b1;
    end else begin
      if (byteValid) data_q <= {sr_q, sda_f};
      if (ackValid)  ack_q  <= sda_f;
      if (start_cond || stop_cond || to_hit) begin
        bit_cnt_q <= '0;
        sr_q      <= '0;
      end else if (in_active && sclRise) begin
        if (bit_cnt_q == 4'd8) begin
          bit_cnt_q <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          sr_q      <= {sr_q[5:0], sda_f};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_monitor
//   Directed bench for i2c_bus_monitor. Each step drives a short bus pattern.
//   Immediate assertions then compare the results against hand-computed
//   values. A negedge monitor counts the event pulses for the
//   frame-level checks.
// ---------------------------------------------------------------------------
module tb_i2c_bus_monitor;

  logic       clk = 1'b0;
  logic       rst_an, rawScl, rawSda;
  logic       scl, sda, sclRise, sclFall, sdaRise, sdaFall;
  logic       start, rstart, stop, busBusy, byteValid, ackValid, ackBit, sclTimeout;
  logic [3:0] bitCnt;
  logic [7:0] dataByte;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0, n_rstart = 0, n_stop = 0, n_sdafall = 0;
  int n_bv = 0, n_av = 0, n_to = 0, n_free = 0;
  int t_stop = 0, t_free = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_ack = 1'b1;
  logic       prev_busy = 1'b0;
  logic       cur_sda;
  int b_start, b_rstart, b_stop, b_bv, b_av, b_free;

  i2c_bus_monitor #(
    .SYNC_STAGES(2), .FILT_DEPTH(3), .BUSFREE_CYCLES(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_an(rst_an), .rawScl(rawScl), .rawSda(rawSda),
    .scl(scl), .sda(sda), .sclRise(sclRise), .sclFall(sclFall),
    .sdaRise(sdaRise), .sdaFall(sdaFall), .start(start), .rstart(rstart),
    .stop(stop), .busBusy(busBusy), .bitCnt(bitCnt), .byteValid(byteValid),
    .dataByte(dataByte), .ackValid(ackValid), .ackBit(ackBit),
    .sclTimeout(sclTimeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst_an) begin
      prev_busy = 1'b0;
    end else begin
      if (start)   n_start++;
      if (rstart)  n_rstart++;
      if (stop) begin n_stop++; t_stop = cyc; end
      if (sdaFall) n_sdafall++;
      if (byteValid) begin n_bv++; last_byte = dataByte; end
      if (ackValid)  begin n_av++; last_ack = ackBit; end
      if (sclTimeout) n_to++;
      if (prev_busy && !busBusy) begin n_free++; t_free = cyc; end
      prev_busy = busBusy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic c, input logic d, input int n);
    rawScl = c;
    rawSda = d;
    cycles(n);
  endtask

  task automatic i2c_start();
    drive(1'b1, 1'b0, 6);
    cur_sda = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, cur_sda, 6);
    drive(1'b0, b, 6);
    drive(1'b1, b, 6);
    cur_sda = b;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic i2c_stop(input int hold);
    drive(1'b0, cur_sda, 6);
    drive(1'b0, 1'b0, 6);
    drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, hold);
    cur_sda = 1'b1;
  endtask

  task automatic i2c_rstart();
    drive(1'b0, cur_sda, 6);
    drive(1'b0, 1'b1, 6);
    drive(1'b1, 1'b1, 6);
    drive(1'b1, 1'b0, 6);
    cur_sda = 1'b0;
  endtask

  initial begin
    rst_an = 1'b0; rawScl = 1'b1; rawSda = 1'b1; cur_sda = 1'b1;
    cycles(3);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busBusy), 32'd0);
    chk("rst_bitcnt", 32'(bitCnt), 32'd0);
    chk("rst_data", 32'(dataByte), 32'h00);
    chk("rst_ack", 32'(ackBit), 32'd1);
    chk("rst_start", 32'(start), 32'd0);
    rst_an = 1'b1;
    cycles(3);

    // 1: a 2-cycle glitch is rejected, and a held fall appears 5 cycles later
    rawSda = 1'b0; cycles(2); rawSda = 1'b1; cycles(8);
    chk("t1_glitch_fall", 32'(n_sdafall), 32'd0);
    chk("t1_glitch_start", 32'(n_start), 32'd0);
    chk("t1_glitch_sda", 32'(sda), 32'd1);
    rawSda = 1'b0; cycles(4);
    chk("t1_sda_c4", 32'(sda), 32'd1);
    cycles(1);
    chk("t1_sda_c5", 32'(sda), 32'd0);
    chk("t1_sdafall_c5", 32'(sdaFall), 32'd1);
    chk("t1_start_c5", 32'(start), 32'd1);
    chk("t1_busy_c5", 32'(busBusy), 32'd0);
    cycles(1);
    chk("t1_busy_c6", 32'(busBusy), 32'd1);
    chk("t1_start_c6", 32'(start), 32'd0);
    cycles(4);
    cur_sda = 1'b0;

    // 2: byte 0xA5 with ACK, then STOP and the bus-free hold-off
    send_byte(8'hA5);
    send_bit(1'b0);
    chk("t2_bv_cnt", 32'(n_bv), 32'd1);
    chk("t2_byte", 32'(last_byte), 32'hA5);
    chk("t2_av_cnt", 32'(n_av), 32'd1);
    chk("t2_ackbit", 32'(last_ack), 32'd0);
    chk("t2_bitcnt_wrap", 32'(bitCnt), 32'd0);
    i2c_stop(20);
    chk("t2_stop_cnt", 32'(n_stop), 32'd1);
    chk("t2_free_cnt", 32'(n_free), 32'd1);
    chk("t2_free_delay", 32'(t_free - t_stop), 32'd8);
    chk("t2_busy_end", 32'(busBusy), 32'd0);

    // 3: partial nibble, repeated START, then byte 0x3C
    b_start = n_start; b_rstart = n_rstart; b_bv = n_bv; b_av = n_av;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("t3_bitcnt_part", 32'(bitCnt), 32'd4);
    i2c_rstart();
    chk("t3_rstart", 32'(n_rstart - b_rstart), 32'd1);
    chk("t3_start_once", 32'(n_start - b_start), 32'd1);
    chk("t3_bitcnt_clr", 32'(bitCnt), 32'd0);
    chk("t3_no_bv", 32'(n_bv - b_bv), 32'd0);
    chk("t3_data_hold", 32'(dataByte), 32'hA5);
    for (int i = 7; i >= 0; i--) begin
      send_bit(((8'h3C >> i) & 8'h01) != 8'h00);
      chk("t3_bitcnt", 32'(bitCnt), 32'(8 - i));
    end
    chk("t3_bv", 32'(n_bv - b_bv), 32'd1);
    chk("t3_byte", 32'(last_byte), 32'h3C);
    send_bit(1'b1);
    chk("t3_bitcnt_ack", 32'(bitCnt), 32'd0);
    chk("t3_av", 32'(n_av - b_av), 32'd1);
    chk("t3_nack", 32'(last_ack), 32'd1);
    i2c_stop(20);

    // 4: STOP followed by START 4 cycles later, within the hold-off
    i2c_start();
    b_start = n_start; b_rstart = n_rstart; b_stop = n_stop; b_free = n_free;
    i2c_stop(4);
    drive(1'b1, 1'b0, 6);
    cur_sda = 1'b0;
    chk("t4_stop", 32'(n_stop - b_stop), 32'd1);
    chk("t4_start", 32'(n_start - b_start), 32'd1);
    chk("t4_no_rstart", 32'(n_rstart - b_rstart), 32'd0);
    chk("t4_never_free", 32'(n_free - b_free), 32'd0);
    chk("t4_busy", 32'(busBusy), 32'd1);
    i2c_stop(20);

    // 5: asynchronous reset after 5 bits, then a clean frame
    i2c_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("t5_bitcnt_pre", 32'(bitCnt), 32'd5);
    rst_an = 1'b0;
    #1;
    chk("t5_rst_bitcnt", 32'(bitCnt), 32'd0);
    chk("t5_rst_busy", 32'(busBusy), 32'd0);
    chk("t5_rst_data", 32'(dataByte), 32'h00);
    chk("t5_rst_ack", 32'(ackBit), 32'd1);
    chk("t5_rst_lines", 32'({scl, sda}), 32'd3);
    chk("t5_rst_pulses", 32'({sclRise, sclFall, sdaRise, sdaFall}), 32'd0);
    drive(1'b1, 1'b1, 2);
    rst_an = 1'b1;
    cycles(8);
    cur_sda = 1'b1;
    b_bv = n_bv; b_av = n_av;
    i2c_start();
    send_byte(8'h5A);
    send_bit(1'b1);
    i2c_stop(20);
    chk("t5_bv", 32'(n_bv - b_bv), 32'd1);
    chk("t5_byte", 32'(last_byte), 32'h5A);
    chk("t5_av", 32'(n_av - b_av), 32'd1);
    chk("t5_ack", 32'(last_ack), 32'd1);
    chk("t5_idle", 32'(busBusy), 32'd0);

    // 6: SCL held low after START
    i2c_start();
    drive(1'b0, 1'b0, 5);
    chk("t6_sclfall", 32'(sclFall), 32'd1);
    cycles(99);
    chk("t6_to_early", 32'(sclTimeout), 32'd0);
    cycles(1);
`ifdef I2C_TIMEOUT_EN
    chk("t6_to_pulse", 32'(sclTimeout), 32'd1);
    cycles(1);
    chk("t6_busy_after", 32'(busBusy), 32'd0);
`else
    chk("t6_to_pulse", 32'(sclTimeout), 32'd0);
    cycles(1);
    chk("t6_busy_after", 32'(busBusy), 32'd1);
`endif
    chk("t6_bitcnt", 32'(bitCnt), 32'd0);
    i2c_stop(20);
`ifdef I2C_TIMEOUT_EN
    chk("t6_to_count", 32'(n_to), 32'd1);
`else
    chk("t6_to_count", 32'(n_to), 32'd0);
`endif
    chk("t6_idle", 32'(busBusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
